hazard_controller: RTL
======================

# hazard_controller

Pipeline sequencing controller for the 5-stage RV32I core. Observes the decode, execute, memory and writeback stages and produces per-stage stall and flush enables plus execute-stage operand forwarding selects. Sequences multi-cycle data-memory accesses through a small FSM with a watchdog. Sits beside the stage modules and drives their pipeline-register enable/clear inputs.

## Interface
- MEM_TIMEOUT, 16, max consecutive cycles of data-memory wait before error (≥2)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- Rs1D, Rs2D  in  5  source regs of instruction in D
- Rs1E, Rs2E, RdE  in  5  source/dest regs in E
- RegWriteE, ResultSrcE, PCSrcE  in  1  E write-enable, E is-load, E branch/jump taken
- RdM, RdW  in  5  dest regs in M, W
- RegWriteM, RegWriteW  in  1  write enables in M, W
- mem_reqM  in  1  M stage issues data-memory access
- mem_ready  in  1  data memory completes access this cycle
- StallF, StallD, StallE, StallM  out  1  hold stage register
- FlushD, FlushE, FlushW  out  1  clear stage register to bubble
- ForwardAE, ForwardBE  out  2  00 regfile, 10 from M, 01 from W
- err  out  1  memory timeout, sticky until reset
- stall_cnt, flush_cnt  out  32  performance counters

## Operation
- FSM states: INIT, RUN, MEM_WAIT, ERROR. Reset → INIT.
- INIT: FlushD=FlushE=1, all stalls 0; next edge → RUN.
- mem_stall = mem_reqM & ~mem_ready (combinational, RUN or MEM_WAIT).
- RUN: mem_stall → StallF/D/E/M=1, FlushW=1, no other flush; next state MEM_WAIT, wait counter ← 1.
- MEM_WAIT: same outputs while mem_stall; counter increments each edge; mem_ready → outputs released same cycle, next RUN. Counter reaching MEM_TIMEOUT with mem_stall still high → ERROR.
- ERROR: StallF/D/E/M=1, FlushW=1, err=1; exits only via reset.
- Without mem stall (RUN/MEM_WAIT):
  - lw_stall = ResultSrcE & RegWriteE & RdE≠0 & (RdE==Rs1D | RdE==Rs2D) → StallF=StallD=1, FlushE=1.
  - PCSrcE → FlushD=FlushE=1, no stalls.
  - lw_stall and PCSrcE are mutually exclusive (one instruction in E); no priority needed.
- Priority: ERROR > INIT > mem_stall > branch/load-use.
- Forwarding (combinational, all states): ForwardAE=10 if RegWriteM & RdM≠0 & RdM==Rs1E; else 01 if RegWriteW & RdW≠0 & RdW==Rs1E; else 00. ForwardBE same with Rs2E. M beats W.
- x0 never forwarded, never causes load-use stall.

## Timing
- Stall/flush/forward outputs combinational from inputs and current state; zero latency.
- State and counters update on posedge clk; async clear on rst low.
- Reset values: state INIT, err 0, wait counter 0, stall_cnt 0, flush_cnt 0; during reset FlushD=FlushE=1, stalls 0, FlushW 0.
- Reset mid-MEM_WAIT: abandon wait, return to INIT; no err.
- mem_ready on first cycle of request: no stall, FSM stays RUN.
- Wait counter width $clog2(MEM_TIMEOUT+1).

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_cnt increments each cycle StallF=1; flush_cnt increments each cycle FlushE=1 (INIT included); both wrap at 2^32.
- Undefined: counters not built; stall_cnt, flush_cnt driven constant 0; ports remain.

## Structure
- Shared package pipeline_pkg: FSM state enum, forward select constants (FWD_RF=00, FWD_W=01, FWD_M=10).
- One sub-module: forward_unit (pure combinational, instantiated once, outputs both selects).

## Test plan
- Reset release: first cycle FlushD=FlushE=1; cycle after, all outputs 0, state RUN.
- add x5 in M (RegWriteM=1, RdM=5), Rs1E=5, also RdW=5 RegWriteW=1 → ForwardAE=10; RdM=0 → ForwardAE=01; Rs2E=0 with RdW=0 → ForwardBE=00.
- ResultSrcE=1, RegWriteE=1, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1 for one cycle; RdE=0 → no stall.
- PCSrcE=1 → FlushD=FlushE=1, StallF=0; flush_cnt +1 with macro.
- mem_reqM=1, mem_ready low 3 cycles then high → StallF/D/E/M and FlushW high exactly 3 cycles, stall_cnt +3, back to RUN, err 0.
- MEM_TIMEOUT=4, mem_ready held low → err=1 after 4 cycles, stalls held; rst pulse → err 0, INIT; repeat with rst at wait cycle 2 → no err.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types for the hazard controller: FSM states and
// execute-stage forwarding select encodings.
package pipeline_pkg;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        MEM_WAIT,
        ERROR
    } hz_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // M beats W; x0 is hardwired zero and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (we_m && rd_m != 5'd0 && rd_m == rs)
            sel = FWD_M;
        else if (we_w && rd_w != 5'd0 && rd_w == rs)
            sel = FWD_W;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Bundle between the pipeline stages and the hazard controller.
// master = stage side, slave = controller side.
interface hazard_controller_if;
    import pipeline_pkg::*;

    logic [4:0]  Rs1D, Rs2D;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        RegWriteE, ResultSrcE, PCSrcE;
    logic [4:0]  RdM, RdW;
    logic        RegWriteM, RegWriteW;
    logic        mem_reqM, mem_ready;
    logic        StallF, StallD, StallE, StallM;
    logic        FlushD, FlushE, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        err;
    logic [31:0] stall_cnt, flush_cnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE,
        output RegWriteE, ResultSrcE, PCSrcE,
        output RdM, RdW, RegWriteM, RegWriteW,
        output mem_reqM, mem_ready,
        input  StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW,
        input  ForwardAE, ForwardBE,
        input  err, stall_cnt, flush_cnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE,
        input  RegWriteE, ResultSrcE, PCSrcE,
        input  RdM, RdW, RegWriteM, RegWriteW,
        input  mem_reqM, mem_ready,
        output StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW,
        output ForwardAE, ForwardBE,
        output err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/forward_unit.sv
// Execute-stage operand forwarding selects, purely combinational.
module forward_unit
    import pipeline_pkg::*;
(
    input  logic [4:0] rs1_e,
    input  logic [4:0] rs2_e,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    output logic [1:0] forward_a,
    output logic [1:0] forward_b
);

    assign forward_a = fwd_sel(rs1_e, rd_m, reg_write_m,
                               rd_w, reg_write_w);
    assign forward_b = fwd_sel(rs2_e, rd_m, reg_write_m,
                               rd_w, reg_write_w);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline stall/flush/forward controller with memory-wait watchdog.
// Define HAZARD_PERF_CNT_EN to build the stall/flush counters.
module hazard_controller
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input logic            clk,
    input logic            rst,
    hazard_controller_if.slave hz
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    hz_state_t       state;
    logic [CW-1:0]   wait_cnt;
    logic            err_q;
    logic            mem_stall;
    logic            lw_stall;
    logic            stall_f, stall_d, stall_e, stall_m;
    logic            flush_d, flush_e, flush_w;

    assign mem_stall = hz.mem_reqM & ~hz.mem_ready;

    assign lw_stall = hz.ResultSrcE & hz.RegWriteE &
                      (hz.RdE != 5'd0) &
                      ((hz.RdE == hz.Rs1D) |
                       (hz.RdE == hz.Rs2D));

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        unique case (state)
            INIT: begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end
            ERROR: begin
                {stall_f, stall_d, stall_e, stall_m} = 4'hf;
                flush_w = 1'b1;
            end
            RUN, MEM_WAIT: begin
                if (mem_stall) begin
                    {stall_f, stall_d, stall_e, stall_m} = 4'hf;
                    flush_w = 1'b1;
                end else begin
                    // Load-use and taken branch cannot coexist in E.
                    if (lw_stall) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                    if (hz.PCSrcE) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= INIT;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= CW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!mem_stall) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                        if (wait_cnt == CW'(MEM_TIMEOUT - 1)) begin
                            state <= ERROR;
                            err_q <= 1'b1;
                        end
                    end
                end
                ERROR: state <= ERROR;
                default: state <= INIT;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_f) stall_q <= stall_q + 32'd1;
            if (flush_e) flush_q <= flush_q + 32'd1;
        end
    end

    assign hz.stall_cnt = stall_q;
    assign hz.flush_cnt = flush_q;
`else
    assign hz.stall_cnt = 32'd0;
    assign hz.flush_cnt = 32'd0;
`endif

    forward_unit u_fwd (
        .rs1_e       (hz.Rs1E),
        .rs2_e       (hz.Rs2E),
        .rd_m        (hz.RdM),
        .reg_write_m (hz.RegWriteM),
        .rd_w        (hz.RdW),
        .reg_write_w (hz.RegWriteW),
        .forward_a   (hz.ForwardAE),
        .forward_b   (hz.ForwardBE)
    );

    assign hz.StallF = stall_f;
    assign hz.StallD = stall_d;
    assign hz.StallE = stall_e;
    assign hz.StallM = stall_m;
    assign hz.FlushD = flush_d;
    assign hz.FlushE = flush_e;
    assign hz.FlushW = flush_w;
    assign hz.err    = err_q;

endmodule
